// File: rtl/tb_latency_memory.sv
//==============================================================================
// Module   : tb_latency_memory
// Brief    : Multi-port TCDM-style bench memory with fixed response latency,
//            per-port outstanding cap and LFSR-driven grant stalls.
//            Optional macro TB_LATENCY_MEMORY_BANK_CONFLICT_EN adds bank
//            conflicts and conflict_cnt_o.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_latency_memory #(
    parameter int              NB_PORTS        = 4,
    parameter int              DATA_WIDTH      = 32,
    parameter int              ADDR_WIDTH      = 32,
    parameter int              MEMORY_SIZE     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int              LATENCY         = 1,
    parameter int              MAX_OUTSTANDING = 8,
    parameter int              STALL_THRESH    = 0,
    parameter logic [15:0]     LFSR_SEED       = 16'hACE1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic                              stallable_i,
    input  logic [NB_PORTS-1:0]               req_i,
    output logic [NB_PORTS-1:0]               gnt_o,
    input  logic [NB_PORTS*ADDR_WIDTH-1:0]    add_i,
    input  logic [NB_PORTS-1:0]               wen_i,
    input  logic [NB_PORTS*DATA_WIDTH/8-1:0]  be_i,
    input  logic [NB_PORTS*DATA_WIDTH-1:0]    data_i,
    output logic [NB_PORTS*DATA_WIDTH-1:0]    r_data_o,
    output logic [NB_PORTS-1:0]               r_valid_o,
`ifdef TB_LATENCY_MEMORY_BANK_CONFLICT_EN
    output logic [31:0]                       conflict_cnt_o,
`endif
    output logic [NB_PORTS-1:0]               err_o
);

    localparam int c_NBYTES = DATA_WIDTH / 8;
    localparam int c_OFF    = $clog2(c_NBYTES);
    localparam int c_IW     = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam int c_CW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CW-1:0]       c_MAX    = c_CW'(MAX_OUTSTANDING);
    localparam logic [10:0]           c_THRESH = 11'(STALL_THRESH);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH  = ADDR_WIDTH'(MEMORY_SIZE);

    logic [DATA_WIDTH-1:0] r_mem   [MEMORY_SIZE];
    logic [15:0]           r_lfsr  [NB_PORTS];
    logic [c_CW-1:0]       r_outst [NB_PORTS];
    logic [LATENCY-1:0]    r_pv    [NB_PORTS];
    logic [DATA_WIDTH-1:0] r_pd    [NB_PORTS][LATENCY];
    logic [NB_PORTS-1:0]   r_err;

    logic [ADDR_WIDTH-1:0] w_off   [NB_PORTS];
    logic [ADDR_WIDTH-1:0] w_word  [NB_PORTS];
    logic [c_IW-1:0]       w_idx   [NB_PORTS];
    logic [DATA_WIDTH-1:0] w_old   [NB_PORTS];
    logic [DATA_WIDTH-1:0] w_merge [NB_PORTS];
    logic [DATA_WIDTH-1:0] w_resp  [NB_PORTS];
    logic [NB_PORTS-1:0]   w_inrng;
    logic [NB_PORTS-1:0]   w_stall;
    logic [NB_PORTS-1:0]   w_elig;
    logic [NB_PORTS-1:0]   w_gnt;
    logic [NB_PORTS-1:0]   w_dec;

    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            w_off[p]   = add_i[p*ADDR_WIDTH +: ADDR_WIDTH] - BASE_ADDR;
            w_word[p]  = w_off[p] >> c_OFF;
            w_inrng[p] = (add_i[p*ADDR_WIDTH +: ADDR_WIDTH] >= BASE_ADDR) && (w_word[p] < c_DEPTH);
            w_idx[p]   = w_word[p][c_IW-1:0];
            w_old[p]   = w_inrng[p] ? r_mem[w_idx[p]] : '0;
            w_merge[p] = w_old[p];
            for (int b = 0; b < c_NBYTES; b++) begin
                if (be_i[p*c_NBYTES + b]) begin
                    w_merge[p][b*8 +: 8] = data_i[p*DATA_WIDTH + b*8 +: 8];
                end
            end
            if (!w_inrng[p]) begin
                w_resp[p] = '0;
            end else if (wen_i[p]) begin
                w_resp[p] = w_old[p];
            end else begin
                w_resp[p] = w_merge[p];
            end
            w_stall[p] = stallable_i & ({1'b0, r_lfsr[p][9:0]} < c_THRESH);
            w_elig[p]  = req_i[p] & enable_i & ~w_stall[p] & (r_outst[p] < c_MAX) & ~rst_i;
        end
    end

`ifdef TB_LATENCY_MEMORY_BANK_CONFLICT_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] w_deny_cnt;

    // Lowest-index eligible port owns its bank this cycle; the rest retry.
    always_comb begin
        w_gnt      = '0;
        w_deny_cnt = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            w_gnt[p] = w_elig[p];
            for (int q = 0; q < p; q++) begin
                if (w_elig[q] && ((32'(w_idx[q]) % NB_PORTS) == (32'(w_idx[p]) % NB_PORTS))) begin
                    w_gnt[p] = 1'b0;
                end
            end
            if (w_elig[p] && !w_gnt[p]) begin
                w_deny_cnt = w_deny_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict_cnt <= '0;
        end else begin
            r_conflict_cnt <= r_conflict_cnt + w_deny_cnt;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
`else
    assign w_gnt = w_elig;
`endif

    assign gnt_o = w_gnt;
    assign err_o = r_err;

    // The counter drops on the edge where r_valid_o rises, so MAX_OUTSTANDING
    // equal to LATENCY sustains one grant per cycle.
    generate
        if (LATENCY == 1) begin : g_dec_lat1
            assign w_dec = w_gnt;
        end else begin : g_dec_latn
            for (genvar gp = 0; gp < NB_PORTS; gp++) begin : g_port
                assign w_dec[gp] = r_pv[gp][LATENCY-2];
            end
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            r_valid_o[p]                         = r_pv[p][LATENCY-1];
            r_data_o[p*DATA_WIDTH +: DATA_WIDTH] = r_pd[p][LATENCY-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= '0;
            for (int p = 0; p < NB_PORTS; p++) begin
                r_lfsr[p]  <= LFSR_SEED ^ 16'(p + 1);
                r_outst[p] <= '0;
                r_pv[p]    <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    r_pd[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NB_PORTS; p++) begin
                r_lfsr[p] <= {1'b0, r_lfsr[p][15:1]} ^ (r_lfsr[p][0] ? 16'hB400 : 16'h0000);
                r_err[p]  <= r_err[p] | (w_gnt[p] & ~w_inrng[p]);
                case ({w_gnt[p], w_dec[p]})
                    2'b10:   r_outst[p] <= r_outst[p] + 1'b1;
                    2'b01:   r_outst[p] <= r_outst[p] - 1'b1;
                    default: r_outst[p] <= r_outst[p];
                endcase
                for (int s = LATENCY - 1; s > 0; s--) begin
                    r_pv[p][s] <= r_pv[p][s-1];
                    r_pd[p][s] <= r_pd[p][s-1];
                end
                r_pv[p][0] <= w_gnt[p];
                r_pd[p][0] <= w_gnt[p] ? w_resp[p] : '0;
            end
        end
    end

    // Ascending port order lets the highest-index writer win each byte lane.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NB_PORTS; p++) begin
            if (w_gnt[p] && !wen_i[p] && w_inrng[p]) begin
                for (int b = 0; b < c_NBYTES; b++) begin
                    if (be_i[p*c_NBYTES + b]) begin
                        r_mem[w_idx[p]][b*8 +: 8] <= data_i[p*DATA_WIDTH + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tb_latency_memory.sv
//==============================================================================
// Module   : tb_tb_latency_memory
// Brief    : Self-checking bench for tb_latency_memory (two configurations).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_tb_latency_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: LATENCY=3, MAX_OUTSTANDING=2, 64 words, no stalls
    logic         a_rst, a_en, a_stl;
    logic [3:0]   a_req, a_wen, a_gnt, a_rvalid, a_err;
    logic [127:0] a_add, a_data, a_rdata;
    logic [15:0]  a_be;
    // Instance B: LATENCY=4, MAX_OUTSTANDING=2, always-stall threshold
    logic         b_rst, b_en, b_stl;
    logic [3:0]   b_req, b_wen, b_gnt, b_rvalid, b_err;
    logic [127:0] b_add, b_data, b_rdata;
    logic [15:0]  b_be;
`ifdef TB_LATENCY_MEMORY_BANK_CONFLICT_EN
    logic [31:0]  a_cc, b_cc;
`endif

    tb_latency_memory #(
        .NB_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEMORY_SIZE(64),
        .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2),
        .STALL_THRESH(0), .LFSR_SEED(16'hACE1)
    ) u_a (
        .clk_i(clk), .rst_i(a_rst), .enable_i(a_en), .stallable_i(a_stl),
        .req_i(a_req), .gnt_o(a_gnt), .add_i(a_add), .wen_i(a_wen),
        .be_i(a_be), .data_i(a_data), .r_data_o(a_rdata), .r_valid_o(a_rvalid),
`ifdef TB_LATENCY_MEMORY_BANK_CONFLICT_EN
        .conflict_cnt_o(a_cc),
`endif
        .err_o(a_err)
    );

    tb_latency_memory #(
        .NB_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEMORY_SIZE(64),
        .BASE_ADDR(32'h0), .LATENCY(4), .MAX_OUTSTANDING(2),
        .STALL_THRESH(1024), .LFSR_SEED(16'hACE1)
    ) u_b (
        .clk_i(clk), .rst_i(b_rst), .enable_i(b_en), .stallable_i(b_stl),
        .req_i(b_req), .gnt_o(b_gnt), .add_i(b_add), .wen_i(b_wen),
        .be_i(b_be), .data_i(b_data), .r_data_o(b_rdata), .r_valid_o(b_rvalid),
`ifdef TB_LATENCY_MEMORY_BANK_CONFLICT_EN
        .conflict_cnt_o(b_cc),
`endif
        .err_o(b_err)
    );

    // Reference model of instance A: word array plus per-port response queues
    logic [31:0] m_mem [64];
    int          q_due [4][$];
    logic [31:0] q_dat [4][$];
    logic [3:0]  m_err, m_gnt;
    int          cyc;
    bit          out_chk;
    logic [31:0] obs_last [4];
    int          obs_vcyc [4];
    int          vcount   [4];
    int          gcyc     [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of A: inputs already driven at the negedge.
    task automatic a_cycle();
        logic [31:0] newmem [64];
        logic [31:0] addr, old, mrg, resp;
        int          outs, idx;
        bit          exp_v;
        #1;
        for (int p = 0; p < 4; p++) begin
            outs = 0;
            for (int k = 0; k < q_due[p].size(); k++) if (q_due[p][k] > cyc) outs++;
            m_gnt[p] = a_req[p] & a_en & ~a_rst & (outs < 2);
            chk($sformatf("gnt%0d@%0d", p, cyc), a_gnt[p], m_gnt[p]);
            if (out_chk) begin
                exp_v = (q_due[p].size() > 0) && (q_due[p][0] == cyc);
                chk($sformatf("valid%0d@%0d", p, cyc), a_rvalid[p], exp_v);
                chk($sformatf("data%0d@%0d", p, cyc), a_rdata[p*32 +: 32], exp_v ? q_dat[p][0] : 32'h0);
                chk($sformatf("err%0d@%0d", p, cyc), a_err[p], m_err[p]);
            end
            if (a_rvalid[p]) begin
                obs_last[p] = a_rdata[p*32 +: 32];
                obs_vcyc[p] = cyc;
                vcount[p]++;
            end
        end
        newmem = m_mem;
        for (int p = 0; p < 4; p++) begin
            if (q_due[p].size() > 0 && q_due[p][0] == cyc) begin
                void'(q_due[p].pop_front());
                void'(q_dat[p].pop_front());
            end
            if (a_rst) begin
                q_due[p].delete();
                q_dat[p].delete();
                m_err[p] = 1'b0;
            end else if (m_gnt[p]) begin
                addr = a_add[p*32 +: 32];
                resp = 32'h0;
                if (addr < 32'd256) begin
                    idx = int'(addr >> 2);
                    old = m_mem[idx];
                    mrg = old;
                    for (int b = 0; b < 4; b++) begin
                        if (a_be[p*4 + b]) mrg[b*8 +: 8] = a_data[p*32 + b*8 +: 8];
                        if (a_be[p*4 + b] && !a_wen[p]) newmem[idx][b*8 +: 8] = a_data[p*32 + b*8 +: 8];
                    end
                    resp = a_wen[p] ? old : mrg;
                end else begin
                    m_err[p] = 1'b1;
                end
                q_due[p].push_back(cyc + 3);
                q_dat[p].push_back(resp);
                gcyc[p] = cyc;
            end
        end
        @(posedge clk);
        m_mem = newmem;
        cyc++;
        @(negedge clk);
    endtask

    task automatic a_idle(input int n);
        for (int i = 0; i < n; i++) a_cycle();
    endtask

    task automatic a_do(input int p, input logic [31:0] addr, input logic w,
                        input logic [3:0] be, input logic [31:0] d);
        bit got;
        got = 1'b0;
        a_req[p] = 1'b1;
        a_add[p*32 +: 32] = addr;
        a_wen[p] = w;
        a_be[p*4 +: 4] = be;
        a_data[p*32 +: 32] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            a_cycle();
            got = m_gnt[p];
        end
        chk("grant_wait", got, 1'b1);
        a_req[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gw, gr, v0, cnt;
        bit          pend [4];
        logic [31:0] w_addr;

        a_rst = 1'b1; a_en = 1'b1; a_stl = 1'b0;
        a_req = '0; a_wen = '0; a_add = '0; a_data = '0; a_be = '0;
        b_rst = 1'b1; b_en = 1'b1; b_stl = 1'b0;
        b_req = '0; b_wen = '0; b_add = '0; b_data = '0; b_be = '0;
        m_err = '0; m_gnt = '0; cyc = 0; out_chk = 1'b0;
        for (int p = 0; p < 4; p++) begin
            obs_last[p] = 32'hFFFF_FFFF; obs_vcyc[p] = 0; vcount[p] = 0; gcyc[p] = 0; pend[p] = 1'b0;
        end
        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;

        // Reset: second reset cycle checks the cleared outputs
        @(negedge clk);
        a_cycle();
        out_chk = 1'b1;
        a_cycle();
        a_rst = 1'b0;

        for (int i = 0; i < 64; i++) a_do(0, i * 4, 1'b0, 4'hF, (i * 32'h0101_0101) ^ 32'hA5A5_A5A5);
        a_idle(4);

        // Write then read at 0x10: both granted in their request cycles, latency 3
        a_do(0, 32'h10, 1'b0, 4'hF, 32'hDEAD_BEEF);
        gw = gcyc[0];
        a_do(0, 32'h10, 1'b1, 4'hF, 32'h0);
        gr = gcyc[0];
        chk("read_grant_next_cycle", gr, gw + 1);
        a_idle(5);
        chk("read_latency", obs_vcyc[0] - gr, 3);
        chk("read_deadbeef", obs_last[0], 32'hDEAD_BEEF);

        // Byte enables
        a_do(0, 32'h20, 1'b0, 4'hF, 32'h1122_3344);
        a_do(0, 32'h20, 1'b0, 4'b0101, 32'hAABB_CCDD);
        a_do(0, 32'h20, 1'b1, 4'hF, 32'h0);
        a_idle(5);
        chk("byte_enable_merge", obs_last[0], 32'h11BB_33DD);

        // Reset one cycle before the first of two in-flight responses
        a_do(0, 32'h10, 1'b1, 4'hF, 32'h0);
        a_do(0, 32'h20, 1'b1, 4'hF, 32'h0);
        a_rst = 1'b1;
        a_cycle();
        a_rst = 1'b0;
        v0 = vcount[0];
        a_idle(6);
        chk("no_valid_after_reset", vcount[0] - v0, 0);
        a_do(0, 32'h14, 1'b1, 4'hF, 32'h0);
        gw = gcyc[0];
        a_do(0, 32'h10, 1'b1, 4'hF, 32'h0);
        chk("outstanding_cleared", gcyc[0], gw + 1);
        a_idle(5);
        chk("data_kept_over_reset", obs_last[0], 32'hDEAD_BEEF);

        // Out-of-range read on port 2
        chk("err_before_oor", a_err[2], 1'b0);
        a_do(2, 32'd256, 1'b1, 4'hF, 32'h0);
        a_idle(4);
        chk("oor_read_zero", obs_last[2], 32'h0);
        chk("oor_err_set", a_err[2], 1'b1);

        // Random multi-port traffic over a small hot region
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 4; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    w_addr  = ($urandom_range(0, 15) == 0) ? 32'h100 + $urandom_range(0, 63)
                                                           : $urandom_range(0, 31);
                    a_add[p*32 +: 32]  = w_addr;
                    a_wen[p]           = $urandom_range(0, 1) != 0;
                    a_be[p*4 +: 4]     = 4'($urandom_range(0, 15));
                    a_data[p*32 +: 32] = $urandom;
                end
                a_req[p] = pend[p];
            end
            a_en = ($urandom_range(0, 9) != 0);
            a_cycle();
            for (int p = 0; p < 4; p++) if (m_gnt[p]) pend[p] = 1'b0;
        end
        a_req = '0;
        a_en  = 1'b1;
        a_idle(6);

        // Instance B: throttling with LATENCY=4, MAX_OUTSTANDING=2
        b_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        b_rst = 1'b0;
        b_req[1] = 1'b1;
        b_wen[1] = 1'b1;
        b_add[32 +: 32] = 32'h0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk($sformatf("thr_gnt@%0d", k), b_gnt[1], (k % 4) < 2);
            chk($sformatf("thr_valid@%0d", k), b_rvalid[1], (k >= 4) && (((k - 4) % 4) < 2));
            if (b_rvalid[1]) cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("thr_resp_count", cnt, 8);
        b_req[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
        end

        // Always-stall threshold, then release
        b_stl = 1'b1;
        b_req[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            chk($sformatf("stall_gnt@%0d", k), b_gnt, 4'h0);
            @(posedge clk); @(negedge clk);
        end
        b_stl = 1'b0;
        #1;
        chk("stall_release_gnt", b_gnt[1], 1'b1);
        @(posedge clk); @(negedge clk);
        b_req[1] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
